// File: rtl/md_wb_pkg.sv
// Shared force-writeback definitions used by the distributors, this arbiter
// and the cell_id-to-network_id converter.
package md_wb_pkg;
  localparam int CELL_ID_W     = 9;
  localparam int PARTICLE_ID_W = 7;
  localparam int FORCE_W       = 32;
  localparam int WB_WIDTH      = CELL_ID_W + PARTICLE_ID_W + 3 * FORCE_W;

  typedef struct packed {
    logic [CELL_ID_W-1:0]     cell_id;
    logic [PARTICLE_ID_W-1:0] particle_id;
    logic [FORCE_W-1:0]       fz;
    logic [FORCE_W-1:0]       fy;
    logic [FORCE_W-1:0]       fx;
  } wb_word_t;
endpackage

// File: rtl/wb_fifo.sv
// Per-source elastic FIFO. The parent gates wr_en/rd_en, so no internal
// protection against writing when full or reading when empty.
module wb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 112,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  // storage is not reset: reset empties the FIFO through the pointers/count
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/force_wb_arbiter.sv
// Round-robin merge of NUM_SRC force-writeback streams onto one registered
// valid/ready injection port, with per-source elastic FIFOs.
module force_wb_arbiter
  import md_wb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int WB_WIDTH   = md_wb_pkg::WB_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int SKID       = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0][WB_WIDTH-1:0]  src_wb_out,
  input  logic [NUM_SRC-1:0]                src_wb_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  output logic [WB_WIDTH-1:0]               bus_data,
  output logic                              bus_valid,
  input  logic                              bus_ready,
  output logic                              idle,
  output logic [NUM_SRC-1:0]                overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]               fifo_full, fifo_empty, wr_en, pop, ovf_evt;
  logic [NUM_SRC-1:0][WB_WIDTH-1:0] fifo_rdata;
  logic [NUM_SRC-1:0][CW-1:0]       fifo_count;
  logic [SW-1:0]                    rr_last, gnt_idx;
  logic                             load, found;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WB_WIDTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[i]),
      .wr_data (src_wb_out[i]),
      .rd_en   (pop[i]),
      .rd_data (fifo_rdata[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i]),
      .count   (fifo_count[i])
    );
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign wr_en[i]   = src_wb_valid[i] & (~fifo_full[i] | pop[i]);
    assign ovf_evt[i] = src_wb_valid[i] & fifo_full[i] & ~pop[i];
  end

  assign load = ~bus_valid | bus_ready;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    pop     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      int idx;
      idx = (int'(rr_last) + k) % NUM_SRC;
      if (!found && !fifo_empty[idx]) begin
        found   = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
    if (load && found) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_valid <= 1'b0;
      bus_data  <= '0;
      rr_last   <= SW'(NUM_SRC - 1);
      src_ready <= '1;
      overflow  <= '0;
    end else begin
      if (load) begin
        bus_valid <= found;
        if (found) begin
          bus_data <= fifo_rdata[gnt_idx];
          rr_last  <= gnt_idx;
        end
      end
      // ready lags occupancy by a cycle; SKID absorbs the in-flight words
      for (int i = 0; i < NUM_SRC; i++) begin
        src_ready[i] <= (CW'(FIFO_DEPTH) - fifo_count[i]) > CW'(SKID);
        overflow[i]  <= overflow[i] | ovf_evt[i];
      end
    end
  end

  assign idle = (&fifo_empty) & ~bus_valid;
endmodule

// File: tb/tb_force_wb_arbiter.sv
// Directed self-checking bench for force_wb_arbiter.
module tb_force_wb_arbiter;
  import md_wb_pkg::*;

  localparam int NS = 2;
  localparam int W  = md_wb_pkg::WB_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NS-1:0][W-1:0] src_wb_out = '0;
  logic [NS-1:0]        src_wb_valid = '0;
  logic [NS-1:0]        src_ready;
  logic [W-1:0]         bus_data;
  logic                 bus_valid;
  logic                 bus_ready = 1'b0;
  logic                 idle;
  logic [NS-1:0]        overflow;

  int assertions = 0;
  int failures   = 0;

  force_wb_arbiter #(.NUM_SRC(NS), .WB_WIDTH(W), .FIFO_DEPTH(8), .SKID(3)) dut (
    .clk(clk), .rst_n(rst_n), .src_wb_out(src_wb_out), .src_wb_valid(src_wb_valid),
    .src_ready(src_ready), .bus_data(bus_data), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .idle(idle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(int s, int n);
    wb_word_t w;
    w.cell_id     = 9'(s + 3);
    w.particle_id = 7'(n);
    w.fz          = 32'(n * 3 + s);
    w.fy          = 32'hF00D_0000 | 32'(n);
    w.fx          = ~32'(n + 16 * s);
    return w;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    src_wb_valid = '0;
    src_wb_out = '0;
    bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    assertions++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL reset_bus_valid: got %b expected 0", bus_valid); end
    assertions++; if (bus_data !== '0) begin failures++; $display("FAIL reset_bus_data: got %h expected 0", bus_data); end
    assertions++; if (src_ready !== 2'b11) begin failures++; $display("FAIL reset_src_ready: got %b expected 11", src_ready); end
    assertions++; if (overflow !== 2'b00) begin failures++; $display("FAIL reset_overflow: got %b expected 00", overflow); end
    assertions++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b expected 1", idle); end
  endtask

  task automatic test_single_source();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      logic ev, ei;
      @(posedge clk); #1;
      src_wb_valid = {1'b0, k < 5};
      src_wb_out[0] = mk(0, k);
      bus_ready = 1'b1;
      @(negedge clk);
      ev = (k >= 2 && k <= 6);
      ei = (k == 0 || k >= 7);
      assertions++; if (bus_valid !== ev) begin failures++; $display("FAIL single_valid c%0d: got %b expected %b", k, bus_valid, ev); end
      if (ev) begin
        assertions++; if (bus_data !== mk(0, k - 2)) begin failures++; $display("FAIL single_data c%0d: got %h expected %h", k, bus_data, mk(0, k - 2)); end
      end
      assertions++; if (idle !== ei) begin failures++; $display("FAIL single_idle c%0d: got %b expected %b", k, idle, ei); end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int k = 0; k < 19; k++) begin
      @(posedge clk); #1;
      src_wb_valid = (k < 8) ? 2'b11 : 2'b00;
      src_wb_out[0] = mk(0, k);
      src_wb_out[1] = mk(1, k);
      bus_ready = 1'b1;
      @(negedge clk);
      if (k >= 2 && k <= 17) begin
        logic [W-1:0] e;
        e = mk((k - 2) % 2, (k - 2) / 2);
        assertions++; if (bus_valid !== 1'b1 || bus_data !== e) begin failures++; $display("FAIL fair_word c%0d: got v=%b %h expected v=1 %h", k, bus_valid, bus_data, e); end
      end
    end
    assertions++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL fair_end_valid: got %b expected 0", bus_valid); end
    assertions++; if (overflow !== 2'b00) begin failures++; $display("FAIL fair_overflow: got %b expected 00", overflow); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      src_wb_valid = {k < 4, 1'b0};
      src_wb_out[1] = mk(1, k);
      bus_ready = (k >= 20);
      @(negedge clk);
      assertions++; if (src_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_src_ready c%0d: got %b expected 1", k, src_ready[1]); end
      if (k >= 2 && k < 20) begin
        assertions++; if (bus_valid !== 1'b1 || bus_data !== mk(1, 0)) begin failures++; $display("FAIL bp_hold c%0d: got v=%b %h expected v=1 %h", k, bus_valid, bus_data, mk(1, 0)); end
      end else if (k >= 20 && k < 24) begin
        assertions++; if (bus_valid !== 1'b1 || bus_data !== mk(1, k - 20)) begin failures++; $display("FAIL bp_drain c%0d: got v=%b %h expected v=1 %h", k, bus_valid, bus_data, mk(1, k - 20)); end
      end else if (k == 24) begin
        assertions++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL bp_end_valid: got %b expected 0", bus_valid); end
      end
    end
  endtask

  // Word 0 moves into the empty output register, so the FIFO holds words 1..8
  // and the 10th word is the first one dropped.
  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); #1;
      src_wb_valid = {1'b0, k < 10};
      src_wb_out[0] = mk(0, k);
      bus_ready = (k >= 11);
      @(negedge clk);
      if (k <= 7) begin
        logic er;
        er = (k <= 6);
        assertions++; if (src_ready[0] !== er) begin failures++; $display("FAIL ovf_src_ready c%0d: got %b expected %b", k, src_ready[0], er); end
      end
      if (k == 9) begin
        assertions++; if (overflow !== 2'b00) begin failures++; $display("FAIL ovf_before: got %b expected 00", overflow); end
      end
      if (k == 10) begin
        assertions++; if (overflow !== 2'b01) begin failures++; $display("FAIL ovf_set: got %b expected 01", overflow); end
        assertions++; if (bus_data !== mk(0, 0)) begin failures++; $display("FAIL ovf_hold: got %h expected %h", bus_data, mk(0, 0)); end
      end
      if (k >= 11 && k <= 19) begin
        assertions++; if (bus_valid !== 1'b1 || bus_data !== mk(0, k - 11)) begin failures++; $display("FAIL ovf_drain c%0d: got v=%b %h expected v=1 %h", k, bus_valid, bus_data, mk(0, k - 11)); end
      end
      if (k == 20) begin
        assertions++; if (bus_valid !== 1'b0 || overflow !== 2'b01) begin failures++; $display("FAIL ovf_end: got v=%b ovf=%b expected v=0 ovf=01", bus_valid, overflow); end
      end
    end
  endtask

  task automatic test_full_boundary();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      src_wb_valid = {1'b0, k <= 9};
      src_wb_out[0] = mk(0, k);
      bus_ready = (k >= 9);
      @(negedge clk);
      if (k == 9) begin
        assertions++; if (bus_data !== mk(0, 0)) begin failures++; $display("FAIL full_head: got %h expected %h", bus_data, mk(0, 0)); end
      end
      if (k >= 10 && k <= 18) begin
        assertions++; if (bus_valid !== 1'b1 || bus_data !== mk(0, k - 9)) begin failures++; $display("FAIL full_drain c%0d: got v=%b %h expected v=1 %h", k, bus_valid, bus_data, mk(0, k - 9)); end
      end
      if (k == 10 || k == 19) begin
        assertions++; if (overflow !== 2'b00) begin failures++; $display("FAIL full_overflow c%0d: got %b expected 00", k, overflow); end
      end
      if (k == 19) begin
        assertions++; if (bus_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL full_end: got v=%b idle=%b expected v=0 idle=1", bus_valid, idle); end
      end
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      src_wb_valid = 2'b01;
      src_wb_out[0] = mk(0, k);
      bus_ready = 1'b0;
      @(negedge clk);
    end
    assertions++; if (overflow !== 2'b01 || bus_valid !== 1'b1) begin failures++; $display("FAIL rst_pre: got ovf=%b v=%b expected ovf=01 v=1", overflow, bus_valid); end
    #2 rst_n = 1'b0;
    #1;
    assertions++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid: got %b expected 0", bus_valid); end
    assertions++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_async_idle: got %b expected 1", idle); end
    assertions++; if (overflow !== 2'b00) begin failures++; $display("FAIL rst_async_overflow: got %b expected 00", overflow); end
    assertions++; if (src_ready !== 2'b11) begin failures++; $display("FAIL rst_async_ready: got %b expected 11", src_ready); end
    src_wb_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic ev;
      @(posedge clk); #1;
      src_wb_valid = {1'b0, k == 0};
      src_wb_out[0] = mk(0, 50);
      bus_ready = 1'b1;
      @(negedge clk);
      ev = (k == 2);
      assertions++; if (bus_valid !== ev) begin failures++; $display("FAIL rst_after_valid c%0d: got %b expected %b", k, bus_valid, ev); end
      if (ev) begin
        assertions++; if (bus_data !== mk(0, 50)) begin failures++; $display("FAIL rst_after_data: got %h expected %h", bus_data, mk(0, 50)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_fairness();
    test_backpressure();
    test_overflow();
    test_full_boundary();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
